// File: rtl/mem_max_scanner_pkg.sv
// Shared widths, constants and FSM encoding for the max-of-array scanner.
package mem_max_scanner_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 16;

    localparam logic [DATA_W-1:0] MIN_SIGNED = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_max_scanner_if.sv
// dataMem port bundle: the scanner drives it as master, memory responds as slave.
interface mem_max_scanner_if;
    import mem_max_scanner_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;

    modport master (output address, memRead, memWrite, writeData, input readData);
    modport slave  (input address, memRead, memWrite, writeData, output readData);
endinterface

// File: rtl/mem_max_scanner_signed_max_cmp.sv
// Combinational running-max step: keeps the earlier index on ties.
module signed_max_cmp
    import mem_max_scanner_pkg::*;
(
    input  logic [DATA_W-1:0] candidate,
    input  logic [DATA_W-1:0] curMax,
    input  logic [LEN_W-1:0]  curIdx,
    input  logic [LEN_W-1:0]  candIdx,
    input  logic              first,
    output logic [DATA_W-1:0] newMax,
    output logic [LEN_W-1:0]  newIdx
);

    logic take_c;

    assign take_c = first || ($signed(candidate) > $signed(curMax));
    assign newMax = take_c ? candidate : curMax;
    assign newIdx = take_c ? candIdx : curIdx;

endmodule

// File: rtl/mem_max_scanner.sv
// Hardware max-of-array engine: streams a block of signed words from dataMem,
// reports maximum and its first index, optionally writes the maximum back.
module mem_max_scanner
    import mem_max_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [LEN_W-1:0]  length,
    input  logic [ADDR_W-1:0] resultAddr,
    input  logic              writeBack,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic [DATA_W-1:0] maxVal,
    output logic [LEN_W-1:0]  maxIdx,
    mem_max_scanner_if.master mem
);

    state_e            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, empty_q, empty_d;
    logic              rd_q, rd_d, wr_q, wr_d, wb_q, wb_d;
    logic [DATA_W-1:0] max_q, max_d, wdata_q, wdata_d;
    logic [LEN_W-1:0]  idx_q, idx_d, len_q, len_d, issue_q, issue_d, recv_q, recv_d;
    logic [ADDR_W-1:0] addr_q, addr_d, res_q, res_d;
    logic [DATA_W-1:0] new_max_c;
    logic [LEN_W-1:0]  new_idx_c;

    signed_max_cmp u_cmp (
        .candidate (mem.readData),
        .curMax    (max_q),
        .curIdx    (idx_q),
        .candIdx   (recv_q),
        .first     (recv_q == '0),
        .newMax    (new_max_c),
        .newIdx    (new_idx_c)
    );

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        empty_d = empty_q;
        rd_d    = rd_q;
        wr_d    = 1'b0;
        wb_d    = wb_q;
        max_d   = max_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        len_d   = len_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        addr_d  = addr_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = length;
                    res_d   = resultAddr;
                    wb_d    = writeBack;
                    busy_d  = 1'b1;
                    recv_d  = '0;
                    issue_d = LEN_W'(1);
                    // An empty request borrows the write slot so done timing stays len+1
                    if (length == '0) begin
                        empty_d = 1'b1;
                        max_d   = MIN_SIGNED;
                        state_d = WRITE;
                    end else begin
                        empty_d = 1'b0;
                        addr_d  = baseAddr;
                        rd_d    = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                max_d  = new_max_c;
                idx_d  = new_idx_c;
                recv_d = recv_q + LEN_W'(1);
                if (issue_q < len_q) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    issue_d = issue_q + LEN_W'(1);
                end
                if (recv_q == len_q - LEN_W'(1)) begin
                    rd_d    = 1'b0;
                    addr_d  = res_q;
                    wdata_d = new_max_c;
                    wr_d    = wb_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wb_q    <= 1'b0;
            max_q   <= MIN_SIGNED;
            wdata_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            issue_q <= '0;
            recv_q  <= '0;
            addr_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            empty_q <= empty_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wb_q    <= wb_d;
            max_q   <= max_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            addr_q  <= addr_d;
            res_q   <= res_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign empty         = empty_q;
    assign maxVal        = max_q;
    assign maxIdx        = idx_q;
    assign mem.address   = addr_q;
    assign mem.memRead   = rd_q;
    assign mem.memWrite  = wr_q;
    assign mem.writeData = wdata_q;

endmodule
